// File: rtl/rf_pkg.sv
// Shared definitions for the 2-read/1-write register file and its clear sequencer.
package rf_pkg;

    // Clear sequencer state encoding
    typedef logic [1:0] rf_state_t;

    localparam rf_state_t RF_IDLE  = 2'd0;
    localparam rf_state_t RF_CLEAR = 2'd1;
    localparam rf_state_t RF_DONE  = 2'd2;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every entry once, one per cycle, then pulses done.
// Exposes a write strobe and address that the register file applies with CLR_VAL.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // Highest entry index; reaching it ends the walk
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    rf_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;

    // State and pointer registers; reset aborts any walk in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RF_IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next-state logic: clr is only honoured from IDLE, never queued
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            RF_IDLE: begin
                if (clr) begin
                    state_next = RF_CLEAR;
                    ptr_next   = '0;
                end
            end
            RF_CLEAR: begin
                if (ptr_reg == LAST_ADDR) begin
                    state_next = RF_DONE;
                end else begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                end
            end
            RF_DONE: begin
                state_next = RF_IDLE;
            end
            default: begin
                state_next = RF_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state only (Moore)
    always_comb begin
        busy     = (state_reg == RF_CLEAR);
        done     = (state_reg == RF_DONE);
        clr_we   = (state_reg == RF_CLEAR);
        clr_addr = ptr_reg;
    end

endmodule

// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read/1-write register file with registered, write-bypassed
// reads and a hardware clear sequencer that fills every entry with CLR_VAL.
module regfile_2r1w_param
    import rf_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               ADDR_W  = 2,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              W,
    input  logic [ADDR_W-1:0] DA,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic [WIDTH-1:0]  entry_q [DEPTH];
    logic [WIDTH-1:0]  a_next, b_next;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic              wr_drop_reg;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .done     (done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // User writes are locked out while the sequencer owns the array, so the
    // two write sources never collide on the same entry.
    assign user_we = W && !busy;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // One storage entry: sequencer clear, else accepted user write
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (clr_we && (clr_addr == ADDR_W'(gi))) begin
                    entry_reg <= CLR_VAL;
                end else if (user_we && (DA == ADDR_W'(gi))) begin
                    entry_reg <= D;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Read port A: next-state value of the addressed entry (bypass on write)
    always_comb begin
        a_next = entry_q[SA];
        if (clr_we && (clr_addr == SA)) begin
            a_next = CLR_VAL;
        end
        if (user_we && (DA == SA)) begin
            a_next = D;
        end
    end

    // Read port B: same bypass rules as port A
    always_comb begin
        b_next = entry_q[SB];
        if (clr_we && (clr_addr == SB)) begin
            b_next = CLR_VAL;
        end
        if (user_we && (DA == SB)) begin
            b_next = D;
        end
    end

    // Registered read data and dropped-write flag
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            a_reg       <= a_next;
            b_reg       <= b_next;
            wr_drop_reg <= W && busy;
        end
    end

    assign A       = a_reg;
    assign B       = b_reg;
    assign wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Scoreboard bench for regfile_2r1w_param (WIDTH=8, ADDR_W=3).
// The driver updates an abstract model per cycle and queues the expected
// outputs; a monitor pops one record per clock and compares.
module tb_regfile_2r1w_param;

    localparam int         WIDTH   = 8;
    localparam int         ADDR_W  = 3;
    localparam int         DEPTH   = 8;
    localparam logic [7:0] CLR_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       W   = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] DA  = '0;
    logic [2:0] SA  = '0;
    logic [2:0] SB  = '0;
    logic [7:0] D   = '0;
    logic [7:0] A, B;
    logic       busy, done, wr_drop;

    regfile_2r1w_param #(
        .WIDTH   (WIDTH),
        .ADDR_W  (ADDR_W),
        .CLR_VAL (CLR_VAL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .W       (W),
        .DA      (DA),
        .D       (D),
        .SA      (SA),
        .SB      (SB),
        .A       (A),
        .B       (B),
        .clr     (clr),
        .busy    (busy),
        .done    (done),
        .wr_drop (wr_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       busy;
        logic       done;
        logic       wr_drop;
    } exp_t;

    exp_t exp_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int busy_seen  = 0;
    int drop_seen  = 0;
    int done_seen  = 0;

    // Abstract model: memory contents, remaining clear steps, done-cycle flag
    logic [7:0] m_mem [DEPTH];
    int         m_clr_left = 0;
    bit         m_in_done  = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expected record per clock, sampled after the edge settles
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("A", A, e.a);
            check("B", B, e.b);
            check("busy", {7'd0, busy}, {7'd0, e.busy});
            check("done", {7'd0, done}, {7'd0, e.done});
            check("wr_drop", {7'd0, wr_drop}, {7'd0, e.wr_drop});
            $display("cyc t=%0t A=%h B=%h busy=%0b done=%0b wr_drop=%0b", $time, A, B, busy, done, wr_drop);
        end
        if (busy === 1'b1)    busy_seen++;
        if (wr_drop === 1'b1) drop_seen++;
        if (done === 1'b1)    done_seen++;
    end

    // Drive one cycle of inputs, advance the model, queue the expected result
    task automatic step(input logic r, input logic w, input logic [2:0] da, input logic [7:0] d,
                        input logic [2:0] sa, input logic [2:0] sb, input logic c);
        exp_t e;
        bit   busy_now;
        @(negedge clk);
        rst = r; W = w; DA = da; D = d; SA = sa; SB = sb; clr = c;
        busy_now = (m_clr_left > 0);
        e = '0;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
            m_clr_left = 0;
            m_in_done  = 1'b0;
        end else begin
            if (busy_now) m_mem[DEPTH - m_clr_left] = CLR_VAL;
            if (w && !busy_now) m_mem[da] = d;
            e.a       = m_mem[sa];
            e.b       = m_mem[sb];
            e.wr_drop = w && busy_now;
            if (busy_now) begin
                m_clr_left--;
                if (m_clr_left == 0) m_in_done = 1'b1;
            end else if (m_in_done) begin
                m_in_done = 1'b0;
            end else if (c) begin
                m_clr_left = DEPTH;
            end
            e.busy = (m_clr_left > 0);
            e.done = m_in_done;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(DEPTH - 1 - i), 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int b0, d0, n0;

        // Reset for two cycles, then read everything back as zero
        step(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        read_all();

        // Plain write then read on the following cycle
        step(1'b0, 1'b1, 3'd3, 8'h5A, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0);

        // Same-cycle write and read of one address: bypass
        step(1'b0, 1'b1, 3'd5, 8'hC3, 3'd5, 3'd5, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 1'b0);

        // Fill with address+1, clear while hammering writes during busy
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 3'(i), 8'(i + 1), 3'(i), 3'(i), 1'b0);
        settle();
        b0 = busy_seen; d0 = drop_seen; n0 = done_seen;
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 3'(i), 8'hEE, 3'(i), 3'd0, 1'b0);
        idle(2);
        settle();
        check("clear_busy_cycles", 8'(busy_seen - b0), 8'(DEPTH));
        check("clear_drop_pulses", 8'(drop_seen - d0), 8'(DEPTH));
        check("clear_done_pulses", 8'(done_seen - n0), 8'd1);
        read_all();

        // Reset three cycles into a clear: abort, entries to zero, no done
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 3'(i), 8'h30 + 8'(i), 3'd0, 3'd0, 1'b0);
        settle();
        n0 = done_seen;
        step(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        read_all();
        idle(2);
        settle();
        check("abort_done_pulses", 8'(done_seen - n0), 8'd0);

        // clr and a write in the same idle cycle: the clear wins afterwards
        step(1'b0, 1'b1, 3'd0, 8'h11, 3'd0, 3'd1, 1'b1);
        idle(DEPTH + 1);
        read_all();

        // Randomised traffic with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
                 3'($urandom), 3'($urandom), ($urandom_range(0, 15) == 0));
        end
        idle(2);

        // Every queued expectation must have been consumed by the monitor
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
